sram_target_bank: RTL and testbench

SRAM_TARGET_BANK -- requirements
Module: sram_target_bank

---
 rtl/sram_target_bank.sv | 145 ++++++++++++++
 tb/tb_sram_target_bank.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_target_bank.sv
// Target-side SRAM bank: independent read and write ports, optional zero-fill after reset,
// and a 1- or 2-cycle registered read path with write-first collision behaviour.
module sram_target_bank #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 13,
  parameter int READ_LAT  = 1,
  parameter int INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_l,
  input  logic              wr_l,
  input  logic [ADDR_W-1:0] rd_address,
  input  logic [ADDR_W-1:0] wr_address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_valid,
  output logic              init_done
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam bit              INIT_EN  = (INIT_ZERO != 32'sd0);
  localparam logic [0:0]      ST_INIT  = 1'b0;
  localparam logic [0:0]      ST_READY = 1'b1;
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [0:0]        state_r;
  logic [0:0]        state_nxt_s;
  logic [ADDR_W-1:0] init_ptr_r;
  logic              init_wr_s;
  logic              rd_fire_s;
  logic              wr_fire_s;
  logic [DATA_W-1:0] rd_word_s;

  // Strobe qualification: ports are only honoured in READY and never on a reset edge.
  always_comb begin
    rd_fire_s = 1'b0;
    wr_fire_s = 1'b0;
    init_wr_s = 1'b0;
    if (rst) begin
      rd_fire_s = 1'b0;
      wr_fire_s = 1'b0;
      init_wr_s = 1'b0;
    end else if (state_r == ST_READY) begin
      rd_fire_s = ~rd_l;
      wr_fire_s = ~wr_l;
    end else begin
      init_wr_s = INIT_EN;
    end
  end

  // Next-state decode for the INIT/READY controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (!INIT_EN) begin
          state_nxt_s = ST_READY;
        end else if (init_ptr_r == PTR_LAST) begin
          state_nxt_s = ST_READY;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_READY: state_nxt_s = ST_READY;
      default:  state_nxt_s = ST_INIT;
    endcase
  end

  // Controller state, fill pointer (wraps naturally) and the registered init_done flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_INIT;
      init_ptr_r <= {ADDR_W{1'b0}};
      init_done  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      init_done <= (state_nxt_s == ST_READY);
      if (init_wr_s) begin
        init_ptr_r <= init_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage array; deliberately has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (init_wr_s) begin
      mem_r[init_ptr_r] <= {DATA_W{1'b0}};
    end else if (wr_fire_s) begin
      mem_r[wr_address] <= wdata;
    end
  end

  // Write-first read word: a same-cycle write to the read address bypasses the array.
  always_comb begin
    rd_word_s = {DATA_W{1'b0}};
    if (wr_fire_s && (wr_address == rd_address)) begin
      rd_word_s = wdata;
    end else begin
      rd_word_s = mem_r[rd_address];
    end
  end

  generate
    if (READ_LAT == 1) begin : g_lat1
      // Single-stage read return.
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata    <= {DATA_W{1'b0}};
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_fire_s;
          if (rd_fire_s) begin
            rdata <= rd_word_s;
          end
        end
      end
    end else begin : g_lat2
      logic [DATA_W-1:0] pipe_data_r;
      logic              pipe_valid_r;

      // Data is captured at the sampling edge so later writes cannot disturb it in flight.
      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_data_r  <= {DATA_W{1'b0}};
          pipe_valid_r <= 1'b0;
          rdata        <= {DATA_W{1'b0}};
          rd_valid     <= 1'b0;
        end else begin
          pipe_valid_r <= rd_fire_s;
          if (rd_fire_s) begin
            pipe_data_r <= rd_word_s;
          end
          rd_valid <= pipe_valid_r;
          if (pipe_valid_r) begin
            rdata <= pipe_data_r;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sram_target_bank.sv
// Scoreboard bench for sram_target_bank: a READ_LAT=1 and a READ_LAT=2 instance share stimulus,
// plus an INIT_ZERO=0 instance for the skip-fill timing.
module tb_sram_target_bank;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_l;
  logic          wr_l;
  logic [AW-1:0] rd_address;
  logic [AW-1:0] wr_address;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata1, rdata2, rdata3;
  logic          rd_valid1, rd_valid2, rd_valid3;
  logic          init_done1, init_done2, init_done3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic          ready_m;
  logic [DW-1:0] q1_d[$];
  logic [DW-1:0] q2_d[$];
  int            q1_c[$];
  int            q2_c[$];

  always #5 clk = ~clk;

  sram_target_bank #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1), .INIT_ZERO(1)) dut_l1 (
    .clk(clk), .rst(rst), .rd_l(rd_l), .wr_l(wr_l), .rd_address(rd_address),
    .wr_address(wr_address), .wdata(wdata), .rdata(rdata1), .rd_valid(rd_valid1),
    .init_done(init_done1));

  sram_target_bank #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(2), .INIT_ZERO(1)) dut_l2 (
    .clk(clk), .rst(rst), .rd_l(rd_l), .wr_l(wr_l), .rd_address(rd_address),
    .wr_address(wr_address), .wdata(wdata), .rdata(rdata2), .rd_valid(rd_valid2),
    .init_done(init_done2));

  sram_target_bank #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1), .INIT_ZERO(0)) dut_nz (
    .clk(clk), .rst(rst), .rd_l(rd_l), .wr_l(wr_l), .rd_address(rd_address),
    .wr_address(wr_address), .wdata(wdata), .rdata(rdata3), .rd_valid(rd_valid3),
    .init_done(init_done3));

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard pop for the READ_LAT=1 instance: result expected at the negedge after the issue edge.
  always @(negedge clk) begin : mon1
    logic [DW-1:0] d;
    int c;
    if (rd_valid1 === 1'b1) begin
      total++;
      if (q1_d.size() == 0) begin
        bad++;
        $display("FAIL lat1_unexpected_valid: got rd_valid=1 rdata=%h at edge %0d, required rd_valid=0", rdata1, cyc);
      end else begin
        d = q1_d.pop_front();
        c = q1_c.pop_front();
        if (rdata1 !== d || cyc - c != 0) begin
          bad++;
          $display("FAIL lat1_read: got rdata=%h at edge %0d, required %h at edge %0d", rdata1, cyc, d, c);
        end
      end
    end
  end

  // Scoreboard pop for the READ_LAT=2 instance: result expected one edge later.
  always @(negedge clk) begin : mon2
    logic [DW-1:0] d;
    int c;
    if (rd_valid2 === 1'b1) begin
      total++;
      if (q2_d.size() == 0) begin
        bad++;
        $display("FAIL lat2_unexpected_valid: got rd_valid=1 rdata=%h at edge %0d, required rd_valid=0", rdata2, cyc);
      end else begin
        d = q2_d.pop_front();
        c = q2_c.pop_front();
        if (rdata2 !== d || cyc - c != 1) begin
          bad++;
          $display("FAIL lat2_read: got rdata=%h at edge %0d, required %h at edge %0d", rdata2, cyc, d, c + 1);
        end
      end
    end
  end

  task automatic drive(input logic rd, input logic [AW-1:0] ra, input logic wr,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    logic [DW-1:0] e;
    @(negedge clk);
    #1;
    rd_l       = ~rd;
    rd_address = ra;
    wr_l       = ~wr;
    wr_address = wa;
    wdata      = wd;
    if (ready_m && rd) begin
      e = (wr && wa == ra) ? wd : ref_mem[ra];
      q1_d.push_back(e);
      q1_c.push_back(cyc + 1);
      q2_d.push_back(e);
      q2_c.push_back(cyc + 1);
    end
    if (ready_m && wr) ref_mem[wa] = wd;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 1'b0, 4'd0, 16'h0000);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    #1;
    rst     = 1'b1;
    rd_l    = 1'b1;
    wr_l    = 1'b1;
    ready_m = 1'b0;
    q1_d.delete();
    q1_c.delete();
    q2_d.delete();
    q2_c.delete();
    @(negedge clk);
    total++;
    if (rdata1 !== 16'h0000 || rd_valid1 !== 1'b0 || init_done1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_state_lat1: got rdata=%h rd_valid=%b init_done=%b, required 0000 0 0", rdata1, rd_valid1, init_done1);
    end
    total++;
    if (rdata2 !== 16'h0000 || rd_valid2 !== 1'b0 || init_done2 !== 1'b0) begin
      bad++;
      $display("FAIL reset_state_lat2: got rdata=%h rd_valid=%b init_done=%b, required 0000 0 0", rdata2, rd_valid2, init_done2);
    end
  endtask

  task automatic wait_init(input bit strobes_low);
    int n1 = 0;
    int n2 = 0;
    int n3 = 0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    if (strobes_low) begin
      rd_l       = 1'b0;
      wr_l       = 1'b0;
      rd_address = 4'd15;
      wr_address = 4'd15;
      wdata      = 16'hFFFF;
    end
    for (int n = 1; n <= 40 && (n1 == 0 || n2 == 0); n++) begin
      @(negedge clk);
      if (n == 1) begin
        total++;
        if (rd_valid3 !== 1'b0 || rdata3 !== 16'h0000) begin
          bad++;
          $display("FAIL nz_first_cycle: got rd_valid=%b rdata=%h, required 0 0000", rd_valid3, rdata3);
        end
      end
      if (init_done1 === 1'b1 && n1 == 0) n1 = n;
      if (init_done2 === 1'b1 && n2 == 0) n2 = n;
      if (init_done3 === 1'b1 && n3 == 0) n3 = n;
      if (n1 != 0 || n2 != 0) begin
        #1;
        rd_l = 1'b1;
        wr_l = 1'b1;
      end
    end
    total++;
    if (n1 != 16 || n2 != 16) begin
      bad++;
      $display("FAIL fill_cycles: got lat1=%0d lat2=%0d cycles, required 16", n1, n2);
    end
    total++;
    if (n3 != 1) begin
      bad++;
      $display("FAIL skip_fill_cycles: got %0d cycles, required 1", n3);
    end
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = 16'h0000;
    ready_m = 1'b1;
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) drive(1'b1, AW'(a), 1'b0, 4'd0, 16'h0000);
    idle();
  endtask

  task automatic drain();
    repeat (3) idle();
    total++;
    if (q1_d.size() != 0 || q2_d.size() != 0) begin
      bad++;
      $display("FAIL missing_results: got %0d/%0d reads outstanding, required 0/0", q1_d.size(), q2_d.size());
    end
    q1_d.delete();
    q1_c.delete();
    q2_d.delete();
    q2_c.delete();
  endtask

  task automatic test_reset();
    pulse_rst();
  endtask

  task automatic test_init_fill();
    wait_init(1'b0);
    read_all();
    drain();
  endtask

  task automatic test_write_read();
    drive(1'b0, 4'd0, 1'b1, 4'd3, 16'h00A5);
    drive(1'b1, 4'd3, 1'b0, 4'd0, 16'h0000);
    idle();
    idle();
    total++;
    if (rdata1 !== 16'h00A5 || rd_valid1 !== 1'b0) begin
      bad++;
      $display("FAIL hold_rdata: got rdata=%h rd_valid=%b, required 00a5 0", rdata1, rd_valid1);
    end
    drain();
  endtask

  task automatic test_write_first();
    drive(1'b0, 4'd0, 1'b1, 4'd5, 16'h0011);
    drive(1'b1, 4'd5, 1'b1, 4'd5, 16'h0077);
    drive(1'b1, 4'd5, 1'b0, 4'd0, 16'h0000);
    drain();
  endtask

  task automatic test_in_flight();
    drive(1'b0, 4'd0, 1'b1, 4'd2, 16'h0010);
    drive(1'b1, 4'd2, 1'b0, 4'd0, 16'h0000);
    drive(1'b0, 4'd0, 1'b1, 4'd2, 16'h0020);
    idle();
    drive(1'b1, 4'd2, 1'b0, 4'd0, 16'h0000);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) drive(1'b0, 4'd0, 1'b1, AW'(8 + i % 4), DW'($urandom));
    for (int i = 0; i < 8; i++) drive(1'b1, AW'(8 + i % 4), 1'b1, AW'(12 + i % 4), DW'($urandom));
    for (int i = 8; i < 16; i++) drive(1'b1, AW'(i), 1'b0, 4'd0, 16'h0000);
    drain();
  endtask

  task automatic test_reset_mid_op();
    drive(1'b0, 4'd0, 1'b1, 4'd9, 16'h1234);
    drive(1'b1, 4'd9, 1'b0, 4'd0, 16'h0000);
    pulse_rst();
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (7) @(negedge clk);
    total++;
    if (init_done1 !== 1'b0 || init_done2 !== 1'b0) begin
      bad++;
      $display("FAIL mid_fill_done: got init_done=%b/%b, required 0/0", init_done1, init_done2);
    end
    pulse_rst();
    wait_init(1'b0);
    read_all();
    drain();
  endtask

  task automatic test_init_strobes();
    drive(1'b0, 4'd0, 1'b1, 4'd15, 16'h5A5A);
    pulse_rst();
    wait_init(1'b1);
    read_all();
    drain();
  endtask

  initial begin
    rst        = 1'b1;
    rd_l       = 1'b1;
    wr_l       = 1'b1;
    rd_address = 4'd0;
    wr_address = 4'd0;
    wdata      = 16'h0000;
    ready_m    = 1'b0;
    test_reset();
    test_init_fill();
    test_write_read();
    test_write_first();
    test_in_flight();
    test_back_to_back();
    test_reset_mid_op();
    test_init_strobes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
